// File: rtl/dcm_clkgen_prog_rx_pkg.sv
// dcm_clkgen_prog_rx_pkg: shared state encoding and command framing constants
package dcm_clkgen_prog_rx_pkg;

    typedef enum logic [2:0] {IDLE, HDR, DATA, GAP, BUSY} state_t;

    // A load is start bit + type bit + DATA_BITS payload, all with PROGEN high
    localparam int   CMD_LEN    = 10;
    localparam int   DATA_BITS  = 8;
    localparam logic TYPE_LOADM = 1'b1;
    localparam logic TYPE_LOADD = 1'b0;

endpackage

// File: rtl/dcm_prog_shift8.sv
// dcm_prog_shift8: LSB-first payload shifter with bit counter and last-bit strobe
module dcm_prog_shift8
    import dcm_clkgen_prog_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 din,
    output logic [DATA_BITS-1:0] word,
    output logic                 done
);

    logic [DATA_BITS-2:0] sr;
    logic [2:0]           cnt;

    // word is the complete payload on the cycle the last bit arrives
    always_comb begin
        word = {din, sr};
        done = en && cnt == 3'(DATA_BITS - 1);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            sr  <= word[DATA_BITS-1:1];
            cnt <= cnt + 3'd1;
        end

endmodule

// File: rtl/dcm_clkgen_prog_rx.sv
// dcm_clkgen_prog_rx: DCM_CLKGEN PROG port responder; DCM_PROG_RX_STATS_EN adds cmd/err counters
module dcm_clkgen_prog_rx
    import dcm_clkgen_prog_rx_pkg::*;
#(
    parameter logic [7:0] DEFAULT_MULT_CODE = 8'd1,
    parameter logic [7:0] DEFAULT_DIV_CODE  = 8'd1,
    parameter int         DONE_LATENCY      = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        progen_i,
    input  logic        progdata_i,
    output logic        progdone_o,
    output logic        locked_o,
    output logic [7:0]  mult_code_o,
    output logic [7:0]  div_code_o,
    output logic        apply_o,
    output logic        proto_err_o
`ifdef DCM_PROG_RX_STATS_EN
    ,
    output logic [15:0] cmd_count_o,
    output logic [7:0]  err_count_o
`endif
);

    state_t     state;
    logic       go_flag, ovr, progen_q, go_d, is_m;
    logic [7:0] pending_m, pending_d, lat_cnt;
    logic [7:0] sh_word;
    logic       sh_done;
    logic       abort, gap_ovr, busy_err, err, go_acc, lat_done;

    dcm_prog_shift8 u_shift (
        .clk  (clk_i),
        .rst  (reset_i),
        .clr  (state == HDR),
        .en   (state == DATA && progen_i),
        .din  (progdata_i),
        .word (sh_word),
        .done (sh_done)
    );

    // ovr makes an overrun report once and poisons a pending Go
    always_comb begin
        abort    = (state == HDR || state == DATA) && !progen_i;
        gap_ovr  = state == GAP && progen_i && !ovr;
        busy_err = state == BUSY && progen_i && !progen_q;
        err      = abort || gap_ovr || busy_err;
        go_acc   = state == GAP && !progen_i && go_flag && !ovr;
        lat_done = state == BUSY && lat_cnt == 8'(DONE_LATENCY - 1);
    end

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state       <= IDLE;
            go_flag     <= 1'b0;
            ovr         <= 1'b0;
            progen_q    <= 1'b0;
            go_d        <= 1'b0;
            is_m        <= 1'b0;
            pending_m   <= DEFAULT_MULT_CODE;
            pending_d   <= DEFAULT_DIV_CODE;
            lat_cnt     <= '0;
            progdone_o  <= 1'b1;
            locked_o    <= 1'b1;
            mult_code_o <= DEFAULT_MULT_CODE;
            div_code_o  <= DEFAULT_DIV_CODE;
            apply_o     <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            progen_q    <= progen_i;
            proto_err_o <= err;
            go_d        <= go_acc;
            apply_o     <= go_d;
            if (go_d) begin
                mult_code_o <= pending_m;
                div_code_o  <= pending_d;
            end
            if (sh_done && is_m)
                pending_m <= sh_word;
            if (sh_done && !is_m)
                pending_d <= sh_word;
            case (state)
                IDLE: if (progen_i) begin
                    state   <= progdata_i ? HDR : GAP;
                    go_flag <= !progdata_i;
                    ovr     <= 1'b0;
                end
                HDR: if (!progen_i) state <= IDLE;
                     else begin
                         is_m  <= progdata_i == TYPE_LOADM;
                         state <= DATA;
                     end
                DATA: if (!progen_i) state <= IDLE;
                      else if (sh_done) state <= GAP;
                GAP: if (progen_i) ovr <= 1'b1;
                     else begin
                         state <= go_acc ? BUSY : IDLE;
                         if (go_acc) begin
                             progdone_o <= 1'b0;
                             locked_o   <= 1'b0;
                             lat_cnt    <= '0;
                         end
                     end
                BUSY: if (lat_done) begin
                          state      <= IDLE;
                          progdone_o <= 1'b1;
                          locked_o   <= 1'b1;
                      end else lat_cnt <= lat_cnt + 8'd1;
                default: state <= IDLE;
            endcase
        end

`ifdef DCM_PROG_RX_STATS_EN
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            cmd_count_o <= '0;
            err_count_o <= '0;
        end else begin
            if ((sh_done || go_acc) && ~&cmd_count_o)
                cmd_count_o <= cmd_count_o + 16'd1;
            if (err && ~&err_count_o)
                err_count_o <= err_count_o + 8'd1;
        end
`endif

endmodule

// File: tb/tb_dcm_clkgen_prog_rx.sv
// tb_dcm_clkgen_prog_rx: scoreboard bench for the PROG port responder
module tb_dcm_clkgen_prog_rx;

    localparam int LAT = 16;

    logic       clk = 0, reset_i = 1, progen = 0, progdata = 0;
    logic       progdone, locked, apply, perr;
    logic [7:0] mult, div;
`ifdef DCM_PROG_RX_STATS_EN
    logic [15:0] cmd_cnt;
    logic [7:0]  err_cnt;
`endif

    dcm_clkgen_prog_rx #(
        .DEFAULT_MULT_CODE (8'd1),
        .DEFAULT_DIV_CODE  (8'd1),
        .DONE_LATENCY      (LAT)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .progen_i    (progen),
        .progdata_i  (progdata),
        .progdone_o  (progdone),
        .locked_o    (locked),
        .mult_code_o (mult),
        .div_code_o  (div),
        .apply_o     (apply),
        .proto_err_o (perr)
`ifdef DCM_PROG_RX_STATS_EN
        ,
        .cmd_count_o (cmd_cnt),
        .err_count_o (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int t; logic [7:0] m; logic [7:0] d;} exp_t;

    int   cyc = 0, checks = 0, passes = 0;
    exp_t apply_q[$];
    int   err_q[$];
    int   done_q[$];
    exp_t e;
    logic [7:0] pend_m = 1, pend_d = 1, act_m = 1, act_d = 1;
    int   n_cmd = 0, n_err = 0;
    logic prev_done = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every DUT-presented event must match the oldest expectation
    always @(negedge clk) begin
        if (!reset_i) begin
            if (perr) begin
                if (err_q.size() == 0) check("unexpected proto_err", cyc, -1);
                else check("proto_err cycle", cyc, err_q.pop_front());
            end
            if (apply) begin
                if (apply_q.size() == 0) check("unexpected apply", cyc, -1);
                else begin
                    e = apply_q.pop_front();
                    check("apply cycle", cyc, e.t);
                    check("mult_code at apply", mult, e.m);
                    check("div_code at apply", div, e.d);
                end
            end
            if (progdone && !prev_done) begin
                if (done_q.size() == 0) check("unexpected progdone rise", cyc, -1);
                else check("progdone rise cycle", cyc, done_q.pop_front());
                check("locked with progdone", locked, 1);
            end
            if (!progdone && prev_done) check("locked drop with progdone", locked, 0);
        end
        prev_done = progdone;
    end

    task automatic drive(input logic pe, input logic pd);
        progen = pe;
        progdata = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0);
    endtask

    task automatic expect_err();
        err_q.push_back(cyc);
        n_err++;
    endtask

    // Load: nbits<8 drops PROGEN early, extra>0 overruns past the 10th cycle
    task automatic load(input bit is_m, input logic [7:0] code, input int nbits,
                        input int extra, input bit busy);
        drive(1, 1);
        if (busy) expect_err();
        drive(1, is_m);
        for (int i = 0; i < nbits; i++) drive(1, code[i]);
        for (int i = 0; i < extra; i++) begin
            drive(1, 1'($urandom_range(0, 1)));
            if (i == 0 && !busy) expect_err();
        end
        drive(0, 0);
        if (!busy && nbits < 8) expect_err();
        if (!busy && nbits == 8) begin
            if (is_m) pend_m = code;
            else pend_d = code;
            n_cmd++;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!progdone && n < 3 * LAT) begin
            drive(0, 0);
            n++;
        end
        if (!progdone) check("progdone timeout", progdone, 1);
    endtask

    task automatic go(input bit busy_load, input logic [7:0] bl_code);
        drive(1, 0);
        drive(0, 0);
        n_cmd++;
        check("progdone low at go accept", progdone, 0);
        apply_q.push_back('{cyc + 1, pend_m, pend_d});
        done_q.push_back(cyc + LAT);
        act_m = pend_m;
        act_d = pend_d;
        if (busy_load) load(1, bl_code, 8, 0, 1);
        wait_done();
    endtask

    task automatic go_overrun();
        drive(1, 0);
        drive(1, 1'($urandom_range(0, 1)));
        expect_err();
        drive(0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 reset_i = 0;
        idle(20);
        check("reset progdone", progdone, 1);
        check("reset locked", locked, 1);
        check("reset mult_code", mult, 1);
        check("reset div_code", div, 1);

        load(0, 8'h04, 8, 0, 0);
        idle(1);
        load(1, 8'h09, 8, 0, 0);
        idle(1);
        go(0, 0);
        idle(2);

        load(1, 8'($urandom), 5, 0, 0);
        idle(2);
        go(0, 0);
        idle(2);

        load(0, 8'h02, 8, 1, 0);
        idle(1);
        go(0, 0);
        idle(2);

        go(1, 8'h20);
        idle(2);
        go(0, 0);
        idle(2);

        for (int k = 0; k < 14; k++) begin
            case ($urandom_range(0, 5))
                0, 1: load(1'($urandom_range(0, 1)), 8'($urandom), 8, 0, 0);
                2: load(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 7), 0, 0);
                3: load(1'($urandom_range(0, 1)), 8'($urandom), 8, $urandom_range(1, 3), 0);
                4: go(1'($urandom_range(0, 1)), 8'($urandom));
                default: go_overrun();
            endcase
            idle($urandom_range(1, 3));
        end
        check("active mult_code", mult, act_m);
        check("active div_code", div, act_d);

        // Asynchronous reset in the middle of a LoadM payload
        drive(1, 1);
        drive(1, 1);
        for (int i = 0; i < 4; i++) drive(1, 1);
        #2 reset_i = 1;
        #1;
        check("async reset progdone", progdone, 1);
        check("async reset locked", locked, 1);
        check("async reset mult_code", mult, 1);
        check("async reset div_code", div, 1);
        check("async reset apply", apply, 0);
        check("async reset proto_err", perr, 0);
`ifdef DCM_PROG_RX_STATS_EN
        check("async reset cmd_count", cmd_cnt, 0);
        check("async reset err_count", err_cnt, 0);
`endif
        pend_m = 1;
        pend_d = 1;
        n_cmd = 0;
        n_err = 0;
        progen = 0;
        progdata = 0;
        @(posedge clk);
        #3 reset_i = 0;
        idle(3);
        go(0, 0);
        idle(3);

        check("apply queue drained", apply_q.size(), 0);
        check("proto_err queue drained", err_q.size(), 0);
        check("progdone queue drained", done_q.size(), 0);
        check("final mult_code", mult, act_m);
        check("final div_code", div, act_d);
`ifdef DCM_PROG_RX_STATS_EN
        check("cmd_count", cmd_cnt, n_cmd);
        check("err_count", err_cnt, n_err);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dcm_clkgen_prog_rx.md
Name: dcm_clkgen_prog_rx

Overview:
Synthesizable responder for the DCM_CLKGEN serial M/D programming port (PROGEN/PROGDATA/PROGDONE), i.e. the receiving end of the clkgen load sequencer. It decodes LoadD, LoadM and Go commands, holds pending and active M/D codes, and drives PROGDONE/locked with a configurable reprogramming latency. It stands in for the primitive in Icarus builds and gives the bench a protocol checker for the loader.

Parameters:
DEFAULT_MULT_CODE, 8'd1, active M code after reset (M-1 encoding; M=2)
DEFAULT_DIV_CODE, 8'd1, active D code after reset (D-1 encoding; D=2)
DONE_LATENCY, 16, PROGCLK cycles from Go to PROGDONE/locked reassertion (legal range 2-255)

Ports:
clk_i  in  1  PROGCLK domain clock; all logic on the rising edge
reset_i  in  1  asynchronous, active-high reset
progen_i  in  1  PROGEN from the loader
progdata_i  in  1  PROGDATA from the loader
progdone_o  out  1  PROGDONE back to the loader
locked_o  out  1  model of the DCM LOCKED output
mult_code_o  out  8  active M-1
div_code_o  out  8  active D-1
apply_o  out  1  one-cycle pulse when the pending codes become active
proto_err_o  out  1  one-cycle pulse on any protocol violation

Behaviour:
- Reset values: progdone_o=1, locked_o=1, mult_code_o=DEFAULT_MULT_CODE, div_code_o=DEFAULT_DIV_CODE, apply_o=0, proto_err_o=0, pending_m=DEFAULT_MULT_CODE, pending_d=DEFAULT_DIV_CODE, state=IDLE.
- States: IDLE, HDR, DATA, GAP, BUSY.
- IDLE, progen_i=1:
  - progdata_i=1 -> HDR (start bit).
  - progdata_i=0 -> Go command -> GAP, with go_flag set.
- HDR (progen_i=1): latch the type bit (1=LoadM, 0=LoadD), clear the bit counter, go to DATA.
- DATA (progen_i=1): shift progdata_i in, LSB first, over exactly 8 cycles. On the 8th bit write pending_m or pending_d, then go to GAP.
- A command occupies exactly 10 consecutive PROGEN-high cycles. PROGEN must be low for at least 1 cycle between commands.
- GAP:
  - progen_i=0: enter BUSY if go_flag is set, otherwise IDLE.
  - progen_i=1: overrun. Pulse proto_err_o and stay in GAP until PROGEN falls. A Go with overrun is discarded.
- Go accepted (GAP->BUSY transition edge):
  - Same edge: progdone_o=0 and locked_o=0.
  - Next edge: mult_code_o/div_code_o <= pending values and apply_o pulses for 1 cycle.
- BUSY: latency counter runs DONE_LATENCY cycles from the GAP->BUSY edge. At terminal count progdone_o=1, locked_o=1, state=IDLE.
- BUSY with progen_i=1: command ignored, proto_err_o pulses once per rising edge of progen_i, pending values unchanged.
- PROGEN falling in HDR or DATA: abort, partial data discarded, proto_err_o pulse, state=IDLE.
- Pending values persist across Go. Go without a new load re-applies the current codes and still runs the full latency.
- reset_i mid-command or in BUSY: immediate return to reset values; partial data is lost.

Optional Feature:
DCM_PROG_RX_STATS_EN:
- Defined: adds outputs cmd_count_o[15:0] (accepted LoadM+LoadD+Go) and err_count_o[7:0] (proto_err_o pulses). Both saturate at all-ones and are cleared by reset_i.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package/include: state encoding constants (IDLE/HDR/DATA/GAP/BUSY), CMD_LEN=10, DATA_BITS=8, command type bit values.
- One natural sub-module: dcm_prog_shift8, an 8-bit LSB-first shift register with bit counter and done strobe, used by DATA.
- Latency counter and the stats counters stay inline.

Test Plan:
- Reset, then idle 20 cycles -> progdone_o=1, locked_o=1, mult_code_o=1, div_code_o=1, no apply_o or proto_err_o.
- LoadD code 8'h04, gap 1, LoadM code 8'h09, gap 1, Go -> progdone_o=0 at Go accept, apply_o pulse next cycle with div_code_o=4 and mult_code_o=9, progdone_o=1 exactly 16 cycles after Go accept.
- LoadM with PROGEN dropped after 5 of the 8 data bits -> proto_err_o single pulse, mult_code_o unchanged after a following Go.
- LoadD 8'h02 followed by an 11th PROGEN-high cycle -> proto_err_o pulse. pending_d=2 is still written, and the next Go applies div_code_o=2.
- Go, then LoadM 8'h20 during BUSY -> proto_err_o pulse, and a later Go leaves mult_code_o unchanged.
- reset_i asserted at data bit 4 of LoadM 8'hFF -> all outputs at reset values asynchronously. With DCM_PROG_RX_STATS_EN, cmd_count_o=0 and err_count_o=0.
